// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative unsigned 16x16 multiply / 16/16 divide unit
// One result bit per clock; start/busy/done handshake toward the sequencer.
module md_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic               op_r;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   shreg;    // multiplier (shifts right) or dividend (shifts left)
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               last;

    always_comb begin
        acc_next = shreg[0] ? acc + mcand : acc;
        // Partial remainder stays below 2^i after i steps, so dropping rem[MSB] is safe.
        rem_sh   = {rem[WIDTH-2:0], shreg[WIDTH-1]};
        trial    = {1'b0, rem_sh} - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : rem_sh;
        quo_next = {quo[WIDTH-2:0], q_bit};
        last     = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_r      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            shreg     <= '0;
            divisor   <= '0;
            rem       <= '0;
            quo       <= '0;
            result_lo <= '0;
            result_hi <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        op_r    <= op;
                        cnt     <= '0;
                        acc     <= '0;
                        rem     <= '0;
                        quo     <= '0;
                        mcand   <= {{WIDTH{1'b0}}, arg1};
                        shreg   <= op ? arg1 : arg2;
                        divisor <= arg2;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_r) begin
                        shreg <= shreg << 1;
                        rem   <= rem_next;
                        quo   <= quo_next;
                    end else begin
                        shreg <= shreg >> 1;
                        mcand <= mcand << 1;
                        acc   <= acc_next;
                    end
                    if (last) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        div_zero <= op_r && (divisor == '0);
                        if (op_r) begin
                            result_lo <= quo_next;
                            result_hi <= rem_next;
                        end else begin
                            result_lo <= acc_next[WIDTH-1:0];
                            result_hi <= acc_next[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
// Reference results come from plain *, / and % on the operands.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] arg1;
    logic [15:0] arg2;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic        busy;
    logic        done;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_lo = '0;
    logic [15:0] exp_hi = '0;
    logic        exp_dz = 1'b0;

    md_unit #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .arg1(arg1), .arg2(arg2),
        .result_lo(result_lo), .result_hi(result_hi),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic o, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        if (!o) begin
            p      = {16'h0, a} * {16'h0, b};
            exp_lo = p[15:0];
            exp_hi = p[31:16];
            exp_dz = 1'b0;
        end else if (b == 16'h0) begin
            exp_lo = 16'hFFFF;
            exp_hi = a;
            exp_dz = 1'b1;
        end else begin
            exp_lo = a / b;
            exp_hi = a % b;
            exp_dz = 1'b0;
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_lo"}, {16'h0, result_lo}, {16'h0, exp_lo});
        check({tag, "_hi"}, {16'h0, result_hi}, {16'h0, exp_hi});
        check({tag, "_dz"}, {31'h0, div_zero}, {31'h0, exp_dz});
    endtask

    // Called #1 after an edge with the unit idle; ignore_at < 0 means no stray start.
    task automatic run_op(input string tag, input logic o, input logic [15:0] a,
                          input logic [15:0] b, input int ignore_at);
        int done_cnt;
        op = o; arg1 = a; arg2 = b; start = 1'b1;
        step();
        start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            check({tag, "_busy"}, {31'h0, busy}, 32'h1);
            check({tag, "_hold"}, {result_hi, result_lo}, {exp_hi, exp_lo});
            if (done) done_cnt++;
            if (c == ignore_at) begin
                start = 1'b1; op = 1'b0; arg1 = 16'd2; arg2 = 16'd2;
            end else begin
                start = 1'b0;
            end
            step();
        end
        model(o, a, b);
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_busy_done"}, {31'h0, busy}, 32'h0);
        check_results(tag);
        step();
        check({tag, "_early_done"}, done_cnt, 0);
        check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
        check({tag, "_idle"}, {31'h0, busy}, 32'h0);
        check_results({tag, "_held"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = 1'b0; arg1 = 16'd7; arg2 = 16'd9;
        step();
        step();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check_results("rst");
        rst = 1'b0; start = 1'b0;
        step();

        run_op("mul_3x5", 1'b0, 16'd3, 16'd5, -1);
        run_op("mul_max", 1'b0, 16'hFFFF, 16'hFFFF, -1);
        run_op("div_100_7", 1'b1, 16'd100, 16'd7, -1);
        run_op("div_zero", 1'b1, 16'h1234, 16'h0, -1);
        run_op("div_ignore", 1'b1, 16'd100, 16'd7, 5);

        // Start held high: one completion every 17 cycles with no idle gap.
        op = 1'b0; arg1 = 16'd3; arg2 = 16'd5; start = 1'b1;
        step();
        model(1'b0, 16'd3, 16'd5);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 16; c++) begin
                check("b2b_busy", {31'h0, busy}, 32'h1);
                check("b2b_nodone", {31'h0, done}, 32'h0);
                step();
            end
            check("b2b_done", {31'h0, done}, 32'h1);
            check("b2b_busy_low", {31'h0, busy}, 32'h0);
            check_results("b2b");
            step();
        end
        start = 1'b0;
        for (int c = 0; c < 16; c++) step();
        check("b2b_last_done", {31'h0, done}, 32'h1);
        step();

        // Reset in the middle of a run aborts it.
        op = 1'b0; arg1 = 16'hFFFF; arg2 = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_lo = '0; exp_hi = '0; exp_dz = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check_results("abort");
        for (int c = 0; c < 12; c++) begin
            check("abort_no_done", {31'h0, done}, 32'h0);
            step();
        end
        run_op("div_9_2", 1'b1, 16'd9, 16'd2, -1);

        for (int n = 0; n < 20; n++) begin
            logic        ro;
            logic [15:0] ra;
            logic [15:0] rb;
            ro = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 16'h0;
                1:       rb = 16'hFFFF;
                2:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            run_op("rand", ro, ra, rb, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multicycle unsigned multiply/divide unit that sits beside the single-cycle arithmetic unit in the execute stage.
- Covers the multiplicative operations the combinational add/sub/shift unit cannot: 16x16->32 multiply, and 16/16 divide producing quotient and remainder.
- Iterative: one bit per clock, with a start/busy/done handshake toward the control sequencer.

Parameters:
- WIDTH, 16, operand width; results are 2xWIDTH bits split into hi/lo words.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when the unit is not busy
- op  in  1  0 = MULU, 1 = DIVU; latched with start
- arg1  in  WIDTH  multiplicand / dividend; latched with start
- arg2  in  WIDTH  multiplier / divisor; latched with start
- result_lo  out  WIDTH  MULU: product[15:0]; DIVU: quotient
- result_hi  out  WIDTH  MULU: product[31:16]; DIVU: remainder
- busy  out  1  high while iterating
- done  out  1  single-cycle pulse when results update
- div_zero  out  1  DIVU with arg2==0; valid with done, held with results

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy, done, div_zero, result_lo and result_hi all 0; counter 0.
  - Reset overrides every other input, including start.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: one-cycle result state; exits to IDLE, or directly back to RUN if start=1.
- Accepting a request:
  - A request is accepted when start=1 at an edge and the state is IDLE or DONE.
  - On acceptance: latch op/arg1/arg2, clear counter, clear working accumulators, go to RUN. busy=1 from the next cycle.
  - start while in RUN is ignored; no queuing, and the latched operands are unchanged.
- RUN timing:
  - Exactly WIDTH (16) cycles; the counter increments each cycle.
  - The edge at which count==WIDTH-1 writes result_lo, result_hi and div_zero, and moves to DONE.
  - busy is high for exactly 16 cycles, then low in the DONE cycle.
  - done=1 only in the DONE cycle.
  - Latency: acceptance edge to done high = 17 edges.
- MULU: shift-add, LSB of multiplier first; 32-bit accumulator; exact unsigned product with no truncation.
- DIVU: restoring division, MSB of dividend first.
  - Each iteration: rem = {rem[14:0], next dividend bit}.
  - Trial subtract is 17 bits wide. If non-negative: rem = difference and the quotient bit is 1; otherwise the quotient bit is 0.
- Divide by zero:
  - No special path; the algorithm naturally yields quotient=0xFFFF and remainder=arg1.
  - div_zero=1 is set when the results are written.
  - Latency is the same 16 cycles.
- Holding results: result_*/div_zero keep their value through IDLE until the next completion. They are not cleared on start, and they do not change during RUN.
- Back-to-back: start in the DONE cycle is accepted, so throughput is one operation per 17 cycles and there is no idle gap.
- Reset mid-RUN: aborts the operation. No done pulse; outputs go to their reset values.
- No overflow flag: MULU cannot overflow 32 bits, and DIVU never overflows.

Test Plan:
- MULU arg1=3, arg2=5, 1-cycle start -> busy high 16 cycles; done at edge 17; result_hi=0x0000, result_lo=0x000F, div_zero=0.
- MULU 0xFFFF*0xFFFF -> result_hi=0xFFFE, result_lo=0x0001.
- DIVU 100/7 -> result_lo=14, result_hi=2, div_zero=0. Also DIVU 0x1234/0 -> result_lo=0xFFFF, result_hi=0x1234, div_zero=1, same latency.
- Start DIVU 100/7, then pulse start with MULU 2*2 at cycle 5 of RUN -> ignored; results 14/2; exactly one done pulse.
- Start held high continuously with a fixed MULU 3*5 -> done every 17 cycles, busy low only in the DONE cycles, results stable at 0/15.
- Start MULU 0xFFFF*0xFFFF, assert rst at cycle 8 of RUN -> no done; all outputs 0 next cycle; a fresh DIVU 9/2 then gives 4/1 on schedule.
